// File: rtl/anon_pkg.sv
// Shared constants for the anonymizer pipeline: default widths, group index sizing and
// the Bloom filter geometry used by bloomfilter and its callers.
package anon_pkg;

    localparam int DATA_WIDTH_D = 32;
    localparam int NUM_GROUPS_D = 16;
    localparam int CNT_WIDTH_D  = 8;
    localparam int L_THRESH_D   = 4;

    localparam int BF_WIDTH = 32;
    localparam int BF_IDX_W = $clog2(BF_WIDTH);
    localparam int BF_K     = 3;

    function automatic int grp_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Odd multiplicative-hash constants; the top BF_IDX_W bits of key*mult pick a bit.
    function automatic logic [31:0] bf_mult(input int k);
        case (k)
            0:       return 32'h9E37_79B1;
            1:       return 32'h85EB_CA77;
            default: return 32'hC2B2_AE3D;
        endcase
    endfunction

endpackage

// File: rtl/bloomfilter.sv
// Combinational Bloom filter probe/insert: sets BF_K hashed bits of the array for one value
// and reports whether all of those bits were already set.
module bloomfilter
    import anon_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_D
) (
    input  logic [BF_WIDTH-1:0]   array_in,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [BF_WIDTH-1:0]   array_out,
    output logic                  match
);

    logic [31:0]         key;
    logic [31:0]         prod;
    logic [BF_WIDTH-1:0] mask;

    always_comb begin
        key  = 32'(data);
        prod = '0;
        mask = '0;
        for (int k = 0; k < BF_K; k++) begin
            prod = key * bf_mult(k);
            mask[prod[31 -: BF_IDX_W]] = 1'b1;
        end
    end

    assign match     = ((array_in & mask) == mask);
    assign array_out = array_in | mask;

endmodule

// File: rtl/ldiv_group_tracker.sv
// Per-group Bloom filter and distinct-value counter; one registered result per accepted beat,
// one cycle after acceptance, held while the consumer stalls.
module ldiv_group_tracker
    import anon_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int NUM_GROUPS = NUM_GROUPS_D,
    parameter int CNT_WIDTH  = CNT_WIDTH_D,
    parameter int L_THRESH   = L_THRESH_D,
    localparam int GRP_W     = grp_w(NUM_GROUPS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [GRP_W-1:0]      in_group,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  clr_valid,
    input  logic [GRP_W-1:0]      clr_group,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [GRP_W-1:0]      out_group,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  out_new,
    output logic                  out_diverse
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [BF_WIDTH-1:0]  arr [NUM_GROUPS];
    logic [CNT_WIDTH-1:0] cnt [NUM_GROUPS];

    logic                 accept;
    logic                 clr_hit;
    logic [BF_WIDTH-1:0]  rd_arr;
    logic [CNT_WIDTH-1:0] rd_cnt;
    logic [BF_WIDTH-1:0]  bf_out;
    logic                 bf_match;
    logic [CNT_WIDTH-1:0] cnt_next;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A same-cycle clear of the beat's group is ordered first: the lookup sees an empty group.
    assign clr_hit = clr_valid && (clr_group == in_group);
    assign rd_arr  = clr_hit ? '0 : arr[in_group];
    assign rd_cnt  = clr_hit ? '0 : cnt[in_group];

    bloomfilter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bf (
        .array_in  (rd_arr),
        .data      (in_data),
        .array_out (bf_out),
        .match     (bf_match)
    );

    always_comb begin
        cnt_next = rd_cnt;
        if (!bf_match && (rd_cnt != CNT_MAX))
            cnt_next = rd_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                arr[g] <= '0;
                cnt[g] <= '0;
            end
            out_valid   <= 1'b0;
            out_group   <= '0;
            out_count   <= '0;
            out_new     <= 1'b0;
            out_diverse <= 1'b0;
        end else begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                if (clr_valid && (clr_group == GRP_W'(g))) begin
                    arr[g] <= '0;
                    cnt[g] <= '0;
                end
            end
            // Placed after the clear loop so the beat's writeback wins for a shared group.
            if (accept) begin
                arr[in_group] <= bf_out;
                cnt[in_group] <= cnt_next;
                out_valid     <= 1'b1;
                out_group     <= in_group;
                out_count     <= cnt_next;
                out_new       <= !bf_match;
                out_diverse   <= (int'(cnt_next) >= L_THRESH);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ldiv_group_tracker.sv
// Directed and randomized checks of ldiv_group_tracker against a value-set Bloom model.
module tb_ldiv_group_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    // default build
    logic        a_in_valid, a_in_ready, a_clr_valid, a_out_valid, a_out_ready, a_out_new, a_out_diverse;
    logic [3:0]  a_in_group, a_clr_group, a_out_group;
    logic [31:0] a_in_data;
    logic [7:0]  a_out_count;
    // narrow-counter build
    logic        b_in_valid, b_in_ready, b_clr_valid, b_out_valid, b_out_ready, b_out_new, b_out_diverse;
    logic [3:0]  b_in_group, b_clr_group, b_out_group;
    logic [31:0] b_in_data;
    logic [1:0]  b_out_count;

    ldiv_group_tracker dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_group(a_in_group), .in_data(a_in_data),
        .clr_valid(a_clr_valid), .clr_group(a_clr_group),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_group(a_out_group),
        .out_count(a_out_count), .out_new(a_out_new), .out_diverse(a_out_diverse)
    );

    ldiv_group_tracker #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_group(b_in_group), .in_data(b_in_data),
        .clr_valid(b_clr_valid), .clr_group(b_clr_group),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_group(b_out_group),
        .out_count(b_out_count), .out_new(b_out_new), .out_diverse(b_out_diverse)
    );

    int tests = 0;
    int fails = 0;

    // Model: each group is the set of values inserted so far; the filter is the union of their hash bits.
    logic [31:0] mv [2][16][$];
    int          mc [2][16];

    function automatic int hpos(input logic [31:0] v, input int k);
        logic [31:0] kc;
        logic [31:0] p;
        kc = (k == 0) ? 32'h9E37_79B1 : (k == 1) ? 32'h85EB_CA77 : 32'hC2B2_AE3D;
        p  = v * kc;
        return int'(p >> 27);
    endfunction

    function automatic bit m_present(input int inst, input int g, input logic [31:0] v);
        for (int k = 0; k < 3; k++) begin
            bit found = 1'b0;
            for (int i = 0; i < mv[inst][g].size(); i++)
                for (int kk = 0; kk < 3; kk++)
                    if (hpos(mv[inst][g][i], kk) == hpos(v, k)) found = 1'b1;
            if (!found) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void m_clear(input int inst, input int g);
        mv[inst][g].delete();
        mc[inst][g] = 0;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 2; i++)
            for (int g = 0; g < 16; g++) m_clear(i, g);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input int inst, input int g, input logic [31:0] v, input bit clr, input int cg);
        bit en;
        int ec;
        int maxc;
        maxc = (inst == 0) ? 255 : 3;
        if (clr) m_clear(inst, cg);
        en = !m_present(inst, g, v);
        if (en) begin
            mv[inst][g].push_back(v);
            if (mc[inst][g] < maxc) mc[inst][g]++;
        end
        ec = mc[inst][g];
        if (inst == 0) begin
            a_in_valid = 1; a_in_group = 4'(g); a_in_data = v;
            a_clr_valid = clr; a_clr_group = 4'(cg); a_out_ready = 1;
        end else begin
            b_in_valid = 1; b_in_group = 4'(g); b_in_data = v;
            b_clr_valid = clr; b_clr_group = 4'(cg); b_out_ready = 1;
        end
        @(posedge clk); #1;
        a_in_valid = 0; a_clr_valid = 0; b_in_valid = 0; b_clr_valid = 0;
        if (inst == 0) begin
            chk("a_vld", 32'(a_out_valid), 1);
            chk("a_grp", 32'(a_out_group), 32'(g));
            chk("a_cnt", 32'(a_out_count), 32'(ec));
            chk("a_new", 32'(a_out_new), 32'(en));
            chk("a_div", 32'(a_out_diverse), 32'(ec >= 4));
        end else begin
            chk("b_vld", 32'(b_out_valid), 1);
            chk("b_cnt", 32'(b_out_count), 32'(ec));
            chk("b_new", 32'(b_out_new), 32'(en));
            chk("b_div", 32'(b_out_diverse), 32'(ec >= 4));
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  held_cnt;
        int          n;

        a_in_valid = 0; a_in_group = 0; a_in_data = 0; a_clr_valid = 0; a_clr_group = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_group = 0; b_in_data = 0; b_clr_valid = 0; b_clr_group = 0; b_out_ready = 1;
        m_reset();

        // Reset and idle
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        chk("rst_vld", 32'(a_out_valid), 0);
        chk("rst_cnt", 32'(a_out_count), 0);
        chk("rst_grp", 32'(a_out_group), 0);
        chk("rst_new", 32'(a_out_new), 0);
        chk("rst_div", 32'(a_out_diverse), 0);
        chk("rst_rdy", 32'(a_in_ready), 1);
        beat(0, 7, 32'h99, 0, 0);

        // Repeat value in group 3
        beat(0, 3, 32'h11, 0, 0);
        beat(0, 3, 32'h11, 0, 0);

        // Four values into group 5
        for (int i = 1; i <= 4; i++) beat(0, 5, 32'(i), 0, 0);

        // Backpressure with a beat waiting
        held_cnt = a_out_count;
        a_out_ready = 0; a_in_valid = 1; a_in_group = 9; a_in_data = 32'h55;
        #1 chk("stall_rdy0", 32'(a_in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_rdy", 32'(a_in_ready), 0);
            chk("stall_vld", 32'(a_out_valid), 1);
            chk("stall_grp", 32'(a_out_group), 5);
            chk("stall_cnt", 32'(a_out_count), 32'(held_cnt));
        end
        beat(0, 9, 32'h55, 0, 0);

        // Clear and beat on the same group, then other groups unaffected
        beat(0, 5, 32'h2, 1, 5);
        beat(0, 3, 32'h11, 0, 0);
        beat(0, 3, 32'h22, 1, 9);
        beat(0, 9, 32'h55, 0, 0);

        // Clearing a group whose result is held does not touch the held result
        held_cnt = a_out_count;
        a_out_ready = 0; a_clr_valid = 1; a_clr_group = 9;
        @(posedge clk); #1;
        a_clr_valid = 0;
        m_clear(0, 9);
        chk("hold_clr_vld", 32'(a_out_valid), 1);
        chk("hold_clr_cnt", 32'(a_out_count), 32'(held_cnt));
        a_out_ready = 1;
        @(posedge clk); #1;
        chk("drain_vld", 32'(a_out_valid), 0);
        beat(0, 9, 32'h55, 0, 0);

        // Randomized stream with repeats and occasional clears
        for (int i = 0; i < 80; i++)
            beat(0, $urandom_range(0, 3), 32'($urandom_range(0, 15)) * 32'h0101_0101,
                 ($urandom_range(0, 9) == 0), $urandom_range(0, 3));

        // Reset mid-stream drops the result in flight
        a_in_valid = 1; a_in_group = 2; a_in_data = 32'h77; a_out_ready = 0;
        @(posedge clk); #1;
        rst_n = 0; a_in_valid = 0;
        @(posedge clk); #1;
        rst_n = 1; a_out_ready = 1;
        m_reset();
        chk("mid_rst_vld", 32'(a_out_valid), 0);
        chk("mid_rst_cnt", 32'(a_out_count), 0);
        beat(0, 2, 32'h77, 0, 0);

        // Narrow counter saturates: five distinct values the model says are new
        n = 0;
        for (int tries = 0; tries < 2000 && n < 5; tries++) begin
            v = $urandom;
            if (!m_present(1, 0, v)) begin
                beat(1, 0, v, 0, 0);
                n++;
            end
        end
        chk("sat_values_found", 32'(n), 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
